// File: rtl/cmt_clk_sequencer.sv
// cmt_clk_sequencer: sequences the CMT reset and LOCKED qualification and arbitrates
// glitch-free read-clock mux changes through break-before-make gating.
// Ports:
//   CLK, RESET (async, active-low)    - clock and reset
//   locked                             - async CMT LOCKED, 2-FF synchronised here
//   sel_req / sel_val                  - level source-change request and requested source
//   cmt_rst, mux_sel, clk_en           - CMT reset, read-clock mux select, consumer enable
//   ready, sel_ack, sel_err            - RUN indicator, completion / rejection pulses
//   fault, retry_cnt                   - sticky lock failure, lock timeouts since last lock
// All outputs are registered; a source change costs 2*GAP_CYCLES+1 cycles.
module cmt_clk_sequencer #(
  parameter int         RST_CYCLES   = 16,
  parameter int         LOCK_TIMEOUT = 1024,
  parameter int         LOCK_STABLE  = 64,
  parameter int         GAP_CYCLES   = 8,
  parameter int         MAX_RETRY    = 3,
  parameter logic [1:0] DEF_SEL      = 2'd2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       locked,
  input  logic       sel_req,
  input  logic [1:0] sel_val,
  output logic       cmt_rst,
  output logic [1:0] mux_sel,
  output logic       clk_en,
  output logic       ready,
  output logic       sel_ack,
  output logic       sel_err,
  output logic       fault,
  output logic [1:0] retry_cnt
);

  // One shared phase counter, wide enough for the largest interval it times.
  localparam int W_RST = $clog2(RST_CYCLES + 1);
  localparam int W_TO  = $clog2(LOCK_TIMEOUT + 1);
  localparam int W_STB = $clog2(LOCK_STABLE + 1);
  localparam int W_GAP = $clog2(GAP_CYCLES + 1);
  localparam int W_A   = (W_RST > W_TO) ? W_RST : W_TO;
  localparam int W_B   = (W_STB > W_GAP) ? W_STB : W_GAP;
  localparam int CW    = (W_A > W_B) ? W_A : W_B;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [1:0]    RETRY_LIM = 2'(MAX_RETRY);
  localparam logic [1:0]    SEL_BAD   = 2'd3;

  typedef enum logic [2:0] {
    S_RST_HOLD,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_GATE_OFF,
    S_SWITCH,
    S_GATE_ON,
    S_FAULT
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_lock_meta;
  logic          r_lock_s;
  logic [1:0]    r_sel_cap;
  logic          r_cmt_rst;
  logic [1:0]    r_mux_sel;
  logic          r_clk_en;
  logic          r_ready;
  logic          r_sel_ack;
  logic          r_sel_err;
  logic          r_fault;
  logic [1:0]    r_retry;

  logic [1:0]    w_retry_nxt;
  logic          w_req_take;

  assign w_retry_nxt = r_retry + 2'd1;
  // A request is not re-sampled in the cycle its ack/err pulse is out, so a
  // requester that drops sel_req on seeing the pulse gets exactly one response.
  assign w_req_take  = sel_req & ~r_sel_ack & ~r_sel_err;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_RST_HOLD;
      r_cnt       <= '0;
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_sel_cap   <= DEF_SEL;
      r_cmt_rst   <= 1'b1;
      r_mux_sel   <= DEF_SEL;
      r_clk_en    <= 1'b0;
      r_ready     <= 1'b0;
      r_sel_ack   <= 1'b0;
      r_sel_err   <= 1'b0;
      r_fault     <= 1'b0;
      r_retry     <= 2'd0;
    end else begin
      r_lock_meta <= locked;
      r_lock_s    <= r_lock_meta;
      r_sel_ack   <= 1'b0;
      r_sel_err   <= 1'b0;

      case (r_state)
        S_RST_HOLD: begin
          if (r_cnt == RST_LAST) begin
            r_state   <= S_WAIT_LOCK;
            r_cmt_rst <= 1'b0;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_WAIT_LOCK: begin
          if (r_lock_s) begin
            r_state <= S_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == TO_LAST) begin
            r_retry   <= w_retry_nxt;
            r_cnt     <= '0;
            r_cmt_rst <= 1'b1;
            if (w_retry_nxt == RETRY_LIM) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state <= S_RST_HOLD;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_STABLE: begin
          if (!r_lock_s) begin
            // A glitch in LOCKED restarts the full timeout window.
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STB_LAST) begin
            r_state  <= S_RUN;
            r_clk_en <= 1'b1;
            r_ready  <= 1'b1;
            r_retry  <= 2'd0;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_RUN, S_GATE_OFF, S_SWITCH, S_GATE_ON: begin
          if (!r_lock_s) begin
            // Lock loss: abandon any switch, keep mux_sel, re-run the CMT reset.
            r_state   <= S_RST_HOLD;
            r_cmt_rst <= 1'b1;
            r_clk_en  <= 1'b0;
            r_ready   <= 1'b0;
            r_cnt     <= '0;
          end else begin
            case (r_state)
              S_RUN: begin
                if (w_req_take) begin
                  if (sel_val == SEL_BAD) begin
                    r_sel_err <= 1'b1;
                  end else if (sel_val == r_mux_sel) begin
                    r_sel_ack <= 1'b1;
                  end else begin
                    r_state   <= S_GATE_OFF;
                    r_sel_cap <= sel_val;
                    r_clk_en  <= 1'b0;
                    r_ready   <= 1'b0;
                    r_cnt     <= '0;
                  end
                end
              end
              S_GATE_OFF: begin
                if (r_cnt == GAP_LAST) begin
                  r_state   <= S_SWITCH;
                  r_mux_sel <= r_sel_cap;
                  r_cnt     <= '0;
                end else begin
                  r_cnt <= r_cnt + CNT_ONE;
                end
              end
              S_SWITCH: begin
                if (r_cnt == GAP_LAST) begin
                  r_state   <= S_GATE_ON;
                  r_clk_en  <= 1'b1;
                  r_sel_ack <= 1'b1;
                  r_cnt     <= '0;
                end else begin
                  r_cnt <= r_cnt + CNT_ONE;
                end
              end
              default: begin
                r_state <= S_RUN;
                r_ready <= 1'b1;
              end
            endcase
          end
        end

        S_FAULT: begin
          r_state <= S_FAULT;
        end

        default: begin
          r_state   <= S_RST_HOLD;
          r_cmt_rst <= 1'b1;
          r_clk_en  <= 1'b0;
          r_ready   <= 1'b0;
          r_cnt     <= '0;
        end
      endcase
    end
  end

  assign cmt_rst   = r_cmt_rst;
  assign mux_sel   = r_mux_sel;
  assign clk_en    = r_clk_en;
  assign ready     = r_ready;
  assign sel_ack   = r_sel_ack;
  assign sel_err   = r_sel_err;
  assign fault     = r_fault;
  assign retry_cnt = r_retry;

endmodule

// File: tb/tb_cmt_clk_sequencer.sv
// tb_cmt_clk_sequencer: directed bench for cmt_clk_sequencer with default parameters.
// Edges are counted from the first rising edge after RESET is released; outputs are
// sampled 1 time unit after each rising edge.
module tb_cmt_clk_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       locked = 1'b0;
  logic       sel_req = 1'b0;
  logic [1:0] sel_val = 2'd0;
  logic       cmt_rst;
  logic [1:0] mux_sel;
  logic       clk_en;
  logic       ready;
  logic       sel_ack;
  logic       sel_err;
  logic       fault;
  logic [1:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  cmt_clk_sequencer dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .locked    (locked),
    .sel_req   (sel_req),
    .sel_val   (sel_val),
    .cmt_rst   (cmt_rst),
    .mux_sel   (mux_sel),
    .clk_en    (clk_en),
    .ready     (ready),
    .sel_ack   (sel_ack),
    .sel_err   (sel_err),
    .fault     (fault),
    .retry_cnt (retry_cnt)
  );

  initial forever #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string ctx);
    chk({ctx, ".cmt_rst"},   32'(cmt_rst),   32'd1);
    chk({ctx, ".mux_sel"},   32'(mux_sel),   32'd2);
    chk({ctx, ".clk_en"},    32'(clk_en),    32'd0);
    chk({ctx, ".ready"},     32'(ready),     32'd0);
    chk({ctx, ".sel_ack"},   32'(sel_ack),   32'd0);
    chk({ctx, ".sel_err"},   32'(sel_err),   32'd0);
    chk({ctx, ".fault"},     32'(fault),     32'd0);
    chk({ctx, ".retry_cnt"}, 32'(retry_cnt), 32'd0);
  endtask

  initial begin
    int lows;
    int acks;
    int n;

    // Power-on reset with locked tied high.
    locked = 1'b1;
    step(3);
    chk_reset_vals("por");

    // Bring-up: cmt_rst high 16 cycles, RUN at 82 +/- 1 edges.
    RESET = 1'b1;
    step(15);
    chk("bringup.cmt_rst_e15", 32'(cmt_rst), 32'd1);
    step(1);
    chk("bringup.cmt_rst_e16", 32'(cmt_rst), 32'd0);
    step(64);
    chk("bringup.ready_e80", 32'(ready), 32'd0);
    step(3);
    chk("bringup.ready_e83", 32'(ready), 32'd1);
    chk("bringup.clk_en", 32'(clk_en), 32'd1);
    chk("bringup.mux_sel", 32'(mux_sel), 32'd2);
    chk("bringup.retry_cnt", 32'(retry_cnt), 32'd0);

    // Request for the already-selected source: immediate ack, no gating.
    sel_req = 1'b1; sel_val = 2'd2;
    step(1);
    chk("same.sel_ack", 32'(sel_ack), 32'd1);
    chk("same.clk_en", 32'(clk_en), 32'd1);
    chk("same.sel_err", 32'(sel_err), 32'd0);
    sel_req = 1'b0;
    step(1);
    chk("same.ack_one_cycle", 32'(sel_ack), 32'd0);

    // Illegal source 3: error pulse, selection unchanged.
    sel_req = 1'b1; sel_val = 2'd3;
    step(1);
    chk("bad.sel_err", 32'(sel_err), 32'd1);
    chk("bad.sel_ack", 32'(sel_ack), 32'd0);
    chk("bad.mux_sel", 32'(mux_sel), 32'd2);
    sel_req = 1'b0;
    step(1);
    chk("bad.err_one_cycle", 32'(sel_err), 32'd0);
    chk("bad.ready", 32'(ready), 32'd1);

    // Switch 2 -> 0; sel_val changes mid-switch must be ignored.
    sel_req = 1'b1; sel_val = 2'd0;
    lows = 0; acks = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (clk_en === 1'b0) lows++;
      if (sel_ack === 1'b1) acks++;
      if (i == 3) sel_val = 2'd1;
      if (i == 7) chk("sw0.mux_sel_before", 32'(mux_sel), 32'd2);
      if (i == 8) chk("sw0.mux_sel_9th_low", 32'(mux_sel), 32'd0);
    end
    chk("sw0.clk_en_low_cycles", 32'(lows), 32'd16);
    chk("sw0.no_early_ack", 32'(acks), 32'd0);
    step(1);
    chk("sw0.gate_on_clk_en", 32'(clk_en), 32'd1);
    chk("sw0.gate_on_sel_ack", 32'(sel_ack), 32'd1);
    chk("sw0.gate_on_ready", 32'(ready), 32'd0);
    chk("sw0.mux_sel_final", 32'(mux_sel), 32'd0);
    sel_req = 1'b0;
    step(1);
    chk("sw0.run_ready", 32'(ready), 32'd1);
    chk("sw0.ack_dropped", 32'(sel_ack), 32'd0);

    // Switch 0 -> 1, then lose lock while in SWITCH (edge k+10).
    sel_req = 1'b1; sel_val = 2'd1;
    step(11);
    chk("loss.in_switch_mux", 32'(mux_sel), 32'd1);
    chk("loss.in_switch_clk_en", 32'(clk_en), 32'd0);
    locked = 1'b0;
    step(2);
    chk("loss.sync_delay", 32'(cmt_rst), 32'd0);
    step(1);
    chk("loss.cmt_rst", 32'(cmt_rst), 32'd1);
    chk("loss.clk_en", 32'(clk_en), 32'd0);
    chk("loss.ready", 32'(ready), 32'd0);
    chk("loss.sel_ack", 32'(sel_ack), 32'd0);
    chk("loss.mux_sel_kept", 32'(mux_sel), 32'd1);
    sel_req = 1'b0;
    locked = 1'b1;
    acks = 0; n = 0;
    while (ready !== 1'b1 && n < 300) begin
      step(1);
      n++;
      if (sel_ack === 1'b1) acks++;
    end
    chk("relock.ready", 32'(ready), 32'd1);
    chk("relock.no_ack", 32'(acks), 32'd0);
    chk("relock.retry_cnt", 32'(retry_cnt), 32'd0);
    chk("relock.mux_sel", 32'(mux_sel), 32'd1);
    chk("relock.clk_en", 32'(clk_en), 32'd1);

    // Async reset in the middle of GATE_OFF.
    sel_req = 1'b1; sel_val = 2'd0;
    step(3);
    chk("arst.pre_gate_off", 32'(clk_en), 32'd0);
    #2 RESET = 1'b0;
    #1;
    chk_reset_vals("arst");
    sel_req = 1'b0;
    locked = 1'b0;
    step(2);

    // Lock never arrives: three timed-out attempts, then sticky fault.
    RESET = 1'b1;
    step(1039);
    chk("to.retry_e1039", 32'(retry_cnt), 32'd0);
    step(1);
    chk("to.retry_e1040", 32'(retry_cnt), 32'd1);
    chk("to.cmt_rst_e1040", 32'(cmt_rst), 32'd1);
    step(16);
    chk("to.cmt_rst_e1056", 32'(cmt_rst), 32'd0);
    step(1024);
    chk("to.retry_e2080", 32'(retry_cnt), 32'd2);
    step(1039);
    chk("to.fault_e3119", 32'(fault), 32'd0);
    chk("to.retry_e3119", 32'(retry_cnt), 32'd2);
    step(1);
    chk("to.fault_e3120", 32'(fault), 32'd1);
    chk("to.retry_e3120", 32'(retry_cnt), 32'd3);
    chk("to.cmt_rst_e3120", 32'(cmt_rst), 32'd1);
    chk("to.clk_en_e3120", 32'(clk_en), 32'd0);
    locked = 1'b1;
    step(200);
    chk("fault.sticky", 32'(fault), 32'd1);
    chk("fault.cmt_rst", 32'(cmt_rst), 32'd1);
    chk("fault.ready", 32'(ready), 32'd0);
    RESET = 1'b0;
    #1;
    chk("fault.cleared", 32'(fault), 32'd0);
    chk("fault.retry_cleared", 32'(retry_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
